tmr_la_selftest: RTL and testbench

User-project self-test engine for the radiation-hardening work: the management core configures and starts a triple-modular-redundant (TMR) counter run through the logic analyzer (LA) bus. The block injects a programmable fault, counts the mismatches the voter corrects, and reports phase and result on mprj_io[37:20], where the LA-test firmware/testbench pair polls them. The same results are also mirrored back to firmware on la_data_out.

---
 rtl/tmr_la_selftest_if.sv | 33 +++
 rtl/tmr_la_selftest.sv | 152 +++++++++++++++
 tb/tb_tmr_la_selftest.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tmr_la_selftest_if.sv
// tmr_la_selftest_if
// Groups the logic-analyzer bus and the user I/O pad signals of the TMR
// self-test engine into one bundle.
//   la_data_in  [127:0] config fields and start bit from the management core
//   la_oenb     [127:0] per-bit enable, a field bit counts only when this bit is 0
//   la_data_out [127:0] mismatch count, final voted value and status for firmware
//   io_out      [37:0]  status and mismatch count on mprj_io[37:20]
//   io_oeb      [37:0]  pad direction, upper 18 pads driven, lower 20 released
// The master modport is the management/testbench side; the slave modport is
// the self-test engine.
interface tmr_la_selftest_if;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;

  modport master (
    output la_data_in,
    output la_oenb,
    input  la_data_out,
    input  io_out,
    input  io_oeb
  );

  modport slave (
    input  la_data_in,
    input  la_oenb,
    output la_data_out,
    output io_out,
    output io_oeb
  );
endinterface

// File: rtl/tmr_la_selftest.sv
// tmr_la_selftest
// Self-test engine for the radiation-hardening work. The management core
// writes a run length N, an injection cycle K, an injection mask and an
// injection enable on the LA bus and pulses start. Three copies of a counter
// then run N cycles; at cycle K the selected copies get a flipped LSB. The
// bitwise majority voter corrects the copies every cycle and each cycle in
// which the copies disagree is counted. At the end the voted value is
// compared with N to give pass or fail.
//   wb_clk_i  sole clock
//   wb_rst_i  synchronous active-high reset
//   bus       tmr_la_selftest_if.slave: LA config/start in, results out on
//             la_data_out and io_out[37:20]
module tmr_la_selftest #(
  parameter int CNT_W = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  tmr_la_selftest_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           r_state,     w_stateNext;
  logic             r_startQ;
  logic [CNT_W-1:0] r_runLen,    w_runLenNext;
  logic [CNT_W-1:0] r_injCycle,  w_injCycleNext;
  logic [2:0]       r_injMask,   w_injMaskNext;
  logic             r_injEn,     w_injEnNext;
  logic [CNT_W-1:0] r_c0,        w_c0Next;
  logic [CNT_W-1:0] r_c1,        w_c1Next;
  logic [CNT_W-1:0] r_c2,        w_c2Next;
  logic [CNT_W-1:0] r_idx,       w_idxNext;
  logic [15:0]      r_count,     w_countNext;
  logic [CNT_W-1:0] r_voted,     w_votedNext;
  logic [1:0]       r_status,    w_statusNext;

  logic [127:0]     w_masked;
  logic             w_start;
  logic             w_startEdge;
  logic [CNT_W-1:0] w_vote;
  logic [CNT_W-1:0] w_voteInc;
  logic             w_mismatch;
  logic             w_inject;
  logic [15:0]      w_countSat;
  logic             w_unusedBits;

  // A field bit is honoured only while its output-enable bar is low.
  assign w_masked    = bus.la_data_in & ~bus.la_oenb;
  assign w_start     = w_masked[63];
  assign w_startEdge = w_start & ~r_startQ;
  // Only a handful of LA bits carry meaning; the rest are deliberately ignored.
  assign w_unusedBits = ^w_masked;

  // Bitwise majority of the three copies and the shared increment.
  assign w_vote     = (r_c0 & r_c1) | (r_c0 & r_c2) | (r_c1 & r_c2);
  assign w_voteInc  = w_vote + ONE;
  assign w_mismatch = (r_c0 != r_c1) || (r_c1 != r_c2);
  assign w_inject   = r_injEn && (r_idx == r_injCycle);
  assign w_countSat = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

  // Next-state and datapath decisions. Everything holds by default; a start
  // edge is only taken while idle or done, so a pulse during a run is lost.
  always_comb begin
    w_stateNext    = r_state;
    w_runLenNext   = r_runLen;
    w_injCycleNext = r_injCycle;
    w_injMaskNext  = r_injMask;
    w_injEnNext    = r_injEn;
    w_c0Next       = r_c0;
    w_c1Next       = r_c1;
    w_c2Next       = r_c2;
    w_idxNext      = r_idx;
    w_countNext    = r_count;
    w_votedNext    = r_voted;
    w_statusNext   = r_status;
    case (r_state)
      IDLE, DONE: begin
        if (w_startEdge) begin
          w_runLenNext   = w_masked[CNT_W-1:0];
          w_injCycleNext = w_masked[16 +: CNT_W];
          w_injMaskNext  = w_masked[34:32];
          w_injEnNext    = w_masked[35];
          w_c0Next       = '0;
          w_c1Next       = '0;
          w_c2Next       = '0;
          w_idxNext      = '0;
          w_countNext    = '0;
          w_statusNext   = 2'b10;
          w_stateNext    = (w_masked[CNT_W-1:0] == '0) ? CHECK : RUN;
        end
      end
      RUN: begin
        if (w_mismatch) w_countNext = w_countSat;
        w_c0Next  = (w_inject && r_injMask[0]) ? (w_voteInc ^ ONE) : w_voteInc;
        w_c1Next  = (w_inject && r_injMask[1]) ? (w_voteInc ^ ONE) : w_voteInc;
        w_c2Next  = (w_inject && r_injMask[2]) ? (w_voteInc ^ ONE) : w_voteInc;
        w_idxNext = r_idx + ONE;
        if (r_idx == r_runLen - ONE) w_stateNext = CHECK;
      end
      CHECK: begin
        // A flip injected on the last RUN cycle is still caught here.
        if (w_mismatch) w_countNext = w_countSat;
        w_votedNext  = w_vote;
        w_statusNext = (w_vote == r_runLen) ? 2'b00 : 2'b01;
        w_stateNext  = DONE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State and datapath registers. Count and status move on the same edge so
  // the pads never show a half-updated result.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= IDLE;
      r_startQ   <= 1'b0;
      r_runLen   <= '0;
      r_injCycle <= '0;
      r_injMask  <= '0;
      r_injEn    <= 1'b0;
      r_c0       <= '0;
      r_c1       <= '0;
      r_c2       <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_voted    <= '0;
      r_status   <= 2'b00;
    end else begin
      r_state    <= w_stateNext;
      r_startQ   <= w_start;
      r_runLen   <= w_runLenNext;
      r_injCycle <= w_injCycleNext;
      r_injMask  <= w_injMaskNext;
      r_injEn    <= w_injEnNext;
      r_c0       <= w_c0Next;
      r_c1       <= w_c1Next;
      r_c2       <= w_c2Next;
      r_idx      <= w_idxNext;
      r_count    <= w_countNext;
      r_voted    <= w_votedNext;
      r_status   <= w_statusNext;
    end
  end

  // Outputs are straight wiring of registers and constants.
  assign bus.la_data_out = {94'd0, r_status, 16'(r_voted), r_count};
  assign bus.io_out      = {r_status, r_count, 20'd0};
  assign bus.io_oeb      = {18'd0, 20'hFFFFF};

endmodule

// File: tb/tb_tmr_la_selftest.sv
// tb_tmr_la_selftest
// Directed bench for tmr_la_selftest: configures runs through the LA bus,
// follows the busy window cycle by cycle and compares status, mismatch count
// and voted value against hand-derived expectations.
module tb_tmr_la_selftest;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;
  int   busy;
  logic [15:0] countTrace [0:2047];

  tmr_la_selftest_if bus ();

  tmr_la_selftest #(.CNT_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges beyond every per-run bound.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Put a config word on the LA bus.
  task automatic setConfig(input int n, input int k, input logic [2:0] mask,
                           input logic en, input logic start);
    logic [127:0] d;
    d        = '0;
    d[15:0]  = 16'(n);
    d[31:16] = 16'(k);
    d[34:32] = mask;
    d[35]    = en;
    d[63]    = start;
    bus.la_data_in = d;
  endtask

  // Start a run, follow it until status leaves busy and return how many
  // cycles showed busy. The count seen at busy sample s (cycle t+s) is kept
  // in countTrace[s]. pulseAt >= 0 re-pulses start during the run.
  task automatic applyStimulus(input int n, input int k, input logic [2:0] mask,
                               input logic en, input int pulseAt,
                               output int busyCycles);
    bit finished;
    setConfig(n, k, mask, en, 1'b1);
    stepCycle();
    checkOutput("startStatus", 128'(bus.io_out[37:36]), 128'(2'b10));
    checkOutput("startCount", 128'(bus.io_out[35:20]), 128'(0));
    setConfig(n, k, mask, en, 1'b0);
    busyCycles = 1;
    countTrace[1] = bus.io_out[35:20];
    finished = 1'b0;
    for (int s = 2; s < 2000; s++) begin
      if (s == pulseAt) setConfig(n, k, mask, en, 1'b1);
      if (s == pulseAt + 1) setConfig(n, k, mask, en, 1'b0);
      stepCycle();
      if (bus.io_out[37:36] != 2'b10) begin
        finished = 1'b1;
        break;
      end
      busyCycles++;
      countTrace[s] = bus.io_out[35:20];
    end
    if (!finished) checkOutput("runTimeout", 128'(1), 128'(0));
  endtask

  // Compare the held result of a finished run.
  task automatic checkResult(input string tag, input logic [1:0] status,
                             input int count, input int voted);
    checkOutput({tag, "Status"}, 128'(bus.io_out[37:36]), 128'(status));
    checkOutput({tag, "Count"}, 128'(bus.io_out[35:20]), 128'(count));
    checkOutput({tag, "Voted"}, 128'(bus.la_data_out[31:16]), 128'(voted));
    checkOutput({tag, "LaStatus"}, 128'(bus.la_data_out[33:32]), 128'(status));
    checkOutput({tag, "LaCount"}, 128'(bus.la_data_out[15:0]), 128'(count));
  endtask

  initial begin
    logic [127:0] idleOr;
    logic [37:0]  oebOr;
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    bus.la_oenb = '0;
    setConfig(0, 0, 3'b000, 1'b0, 1'b0);

    repeat (3) stepCycle();
    checkOutput("rstIoOut", 128'(bus.io_out), 128'(0));
    checkOutput("rstLaOut", bus.la_data_out, 128'(0));
    checkOutput("rstIoOeb", 128'(bus.io_oeb), 128'({18'd0, 20'hFFFFF}));

    // Idle for 100 cycles: nothing may move.
    rst = 1'b0;
    idleOr = '0;
    oebOr  = '0;
    for (int i = 0; i < 100; i++) begin
      stepCycle();
      idleOr = idleOr | bus.la_data_out | 128'(bus.io_out);
      oebOr  = oebOr | (bus.io_oeb ^ {18'd0, 20'hFFFFF});
    end
    checkOutput("idleOutputs", idleOr, 128'(0));
    checkOutput("idleOeb", 128'(oebOr), 128'(0));

    // Clean run: busy for N+1 cycles, voted value equals N.
    applyStimulus(100, 0, 3'b000, 1'b0, -1, busy);
    checkOutput("cleanBusy", 128'(busy), 128'(101));
    checkResult("clean", 2'b00, 0, 100);
    checkOutput("cleanLowPads", 128'(bus.io_out[19:0]), 128'(0));
    checkOutput("cleanLaUpper", bus.la_data_out >> 34, 128'(0));

    // Single fault on copy 1 at idx 10: flip written at cycle t+11, counted
    // on the next edge, visible at t+13. The voter keeps the value correct.
    applyStimulus(100, 10, 3'b010, 1'b1, -1, busy);
    checkOutput("singleBusy", 128'(busy), 128'(101));
    checkOutput("singleCountBefore", 128'(countTrace[12]), 128'(0));
    checkOutput("singleCountAfter", 128'(countTrace[13]), 128'(1));
    checkOutput("singleCountBusyEnd", 128'(countTrace[101]), 128'(1));
    checkResult("single", 2'b00, 1, 100);

    // Double fault at idx 10: v=10, v+1=11, 11^1=10 wins the vote, so the
    // run loses one step and ends at 99.
    applyStimulus(100, 10, 3'b011, 1'b1, -1, busy);
    checkResult("doubleK10", 2'b01, 1, 99);

    // Double fault at idx 9: v+1=10, 10^1=11 wins, the run gains one -> 101.
    applyStimulus(100, 9, 3'b011, 1'b1, -1, busy);
    checkResult("doubleK9", 2'b01, 1, 101);

    // All three copies flipped: no disagreement, value ends at 99, fail.
    applyStimulus(100, 10, 3'b111, 1'b1, -1, busy);
    checkResult("triple", 2'b01, 0, 99);

    // N=0 goes straight to CHECK and passes.
    applyStimulus(0, 0, 3'b000, 1'b0, -1, busy);
    checkOutput("zeroBusy", 128'(busy), 128'(1));
    checkResult("zero", 2'b00, 0, 0);

    // Flip on the last RUN cycle is only seen by CHECK.
    applyStimulus(50, 49, 3'b001, 1'b1, -1, busy);
    checkOutput("lastBusy", 128'(busy), 128'(51));
    checkResult("lastK", 2'b00, 1, 50);

    // K equal to N never injects.
    applyStimulus(50, 50, 3'b010, 1'b1, -1, busy);
    checkResult("kEqN", 2'b00, 0, 50);

    // A second start pulse during RUN must not restart the run.
    applyStimulus(100, 10, 3'b010, 1'b1, 30, busy);
    checkOutput("pulseBusy", 128'(busy), 128'(101));
    checkResult("pulse", 2'b00, 1, 100);

    // Start masked by la_oenb[63]: no run, previous result held.
    bus.la_oenb[63] = 1'b1;
    setConfig(5, 0, 3'b000, 1'b0, 1'b1);
    repeat (5) stepCycle();
    checkResult("masked", 2'b00, 1, 100);
    setConfig(5, 0, 3'b000, 1'b0, 1'b0);
    stepCycle();
    bus.la_oenb[63] = 1'b0;
    stepCycle();
    checkOutput("maskedRelease", 128'(bus.io_out[37:36]), 128'(2'b00));

    // Reset at idx 20 wipes every output on the next edge.
    setConfig(100, 10, 3'b010, 1'b1, 1'b1);
    stepCycle();
    setConfig(100, 10, 3'b010, 1'b1, 1'b0);
    repeat (20) stepCycle();
    checkOutput("midRunBusy", 128'(bus.io_out[37:36]), 128'(2'b10));
    rst = 1'b1;
    stepCycle();
    checkOutput("midRstIoOut", 128'(bus.io_out), 128'(0));
    checkOutput("midRstLaOut", bus.la_data_out, 128'(0));
    checkOutput("midRstIoOeb", 128'(bus.io_oeb), 128'({18'd0, 20'hFFFFF}));
    rst = 1'b0;
    repeat (3) stepCycle();
    checkOutput("postRstIdle", 128'(bus.io_out), 128'(0));

    // Fresh run after reset gives a correct result.
    applyStimulus(30, 5, 3'b100, 1'b1, -1, busy);
    checkOutput("freshBusy", 128'(busy), 128'(31));
    checkResult("fresh", 2'b00, 1, 30);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
